btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 150 +++++++++++++++
 tb/tb_btn_debounce.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// registered level, press/release strobes and a long-press hold flag.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned HOLD_CYCLES     = 27000000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_d;
    logic               btn_d;
    logic               press_d;
    logic               release_d;
    logic               hold_d;

    logic               btn_norm;
    logic               sync_1;
    logic               sync_2;

    assign btn_norm = i_btn ^ BTN_ACTIVE_LOW;

    // Two-flop synchroniser on the normalised (1 = pressed) pad level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_norm;
            sync_2 <= sync_1;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_cnt_d = hold_cnt_q;
        btn_d      = o_btn;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_d     = o_hold;

        // Hold timer runs while the accepted level is pressed; release bounces keep it
        if ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT)) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
                if (hold_cnt_q == (HOLD_MAX - HOLD_ONE)) begin
                    hold_d = 1'b1;
                end
            end
        end

        case (state_q)
            ST_RELEASED: begin
                if (sync_2) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_2) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    btn_d   = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!sync_2) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync_2) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Accepted release overrides a hold that would mature on this edge
                    state_d    = ST_RELEASED;
                    cnt_d      = '0;
                    btn_d      = 1'b0;
                    release_d  = 1'b1;
                    hold_d     = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RELEASED;
            cnt_q      <= '0;
            hold_cnt_q <= '0;
            o_btn      <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_hold     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_cnt_q <= hold_cnt_d;
            o_btn      <= btn_d;
            o_press    <= press_d;
            o_release  <= release_d;
            o_hold     <= hold_d;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: run-length reference model compared every
// cycle, plus fixed-latency scenarios on an active-high and an active-low instance.
module tb_btn_debounce;

    localparam int unsigned D = 4;
    localparam int unsigned H = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic btn_n;

    logic o_btn, o_press, o_release, o_hold;
    logic a_btn, a_press, a_release, a_hold;

    int errors = 0;
    int checks = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_press_a = 0;
    int n_rel_a = 0;

    assign btn_n = ~btn;

    always #5 clk = ~clk;

    btn_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .BTN_ACTIVE_LOW(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn),
        .o_btn(o_btn), .o_press(o_press), .o_release(o_release), .o_hold(o_hold)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .BTN_ACTIVE_LOW(1'b1)) dut_al (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_n),
        .o_btn(a_btn), .o_press(a_press), .o_release(a_release), .o_hold(a_hold)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a new level is accepted once the synchronised input has
    // disagreed with the current level on D+1 consecutive edges.
    bit s1_m = 1'b0, s_m = 1'b0, s_cur = 1'b0;
    bit lvl_m = 1'b0, press_m = 1'b0, rel_m = 1'b0, hold_m = 1'b0;
    bit mdl_valid = 1'b0;
    int run_m = 0;
    int held_m = 0;

    always @(posedge clk) begin
        if (rst) begin
            s1_m = 1'b0; s_m = 1'b0; lvl_m = 1'b0; press_m = 1'b0; rel_m = 1'b0;
            hold_m = 1'b0; run_m = 0; held_m = 0; mdl_valid = 1'b1;
        end else begin
            s_cur = s_m;
            s_m = s1_m;
            s1_m = btn;
            press_m = 1'b0;
            rel_m = 1'b0;
            if (lvl_m) held_m++;
            run_m = (s_cur != lvl_m) ? run_m + 1 : 0;
            if (run_m == int'(D) + 1) begin
                lvl_m = !lvl_m;
                run_m = 0;
                if (lvl_m) begin
                    press_m = 1'b1;
                end else begin
                    rel_m = 1'b1;
                    hold_m = 1'b0;
                    held_m = 0;
                end
            end else if (lvl_m && held_m >= int'(H)) begin
                hold_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("o_btn", o_btn, lvl_m);
            check("o_press", o_press, press_m);
            check("o_release", o_release, rel_m);
            check("o_hold", o_hold, hold_m);
            check("al_o_btn", a_btn, lvl_m);
            check("al_o_press", a_press, press_m);
            check("al_o_release", a_release, rel_m);
            check("al_o_hold", a_hold, hold_m);
            check("strobe_exclusive", o_press & o_release, 1'b0);
            if (o_press) n_press++;
            if (o_release) n_rel++;
            if (a_press) n_press_a++;
            if (a_release) n_rel_a++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_btn"}, o_btn, 1'b0);
        check({tag, "_press"}, o_press, 1'b0);
        check({tag, "_release"}, o_release, 1'b0);
        check({tag, "_hold"}, o_hold, 1'b0);
    endtask

    // Short glitches (<= 3 cycles each) around the target level, ending on it
    task automatic bounce(input logic level);
        int n;
        n = int'($urandom_range(0, 4));
        for (int i = 0; i < n; i++) begin
            btn = level;
            tick(int'($urandom_range(1, 3)));
            btn = !level;
            tick(int'($urandom_range(1, 3)));
        end
        btn = level;
    endtask

    int p0, r0;

    initial begin
        tick(3);
        check_zero_outputs("reset");
        rst = 1'b0;

        // Active-low instance idles high: no strobes
        tick(10);
        check("idle_no_press_al", n_press_a, 0);
        check("idle_no_release_al", n_rel_a, 0);

        // Clean press, latency and hold
        btn = 1'b1;
        tick(6);
        check("clean_btn_early", o_btn, 1'b0);
        tick(1);
        check("clean_btn", o_btn, 1'b1);
        check("clean_press", o_press, 1'b1);
        check("clean_press_al", a_press, 1'b1);
        tick(1);
        check("clean_press_drop", o_press, 1'b0);
        tick(18);
        check("clean_hold_early", o_hold, 1'b0);
        tick(1);
        check("clean_hold", o_hold, 1'b1);

        // Release glitch then stable release
        r0 = n_rel;
        btn = 1'b0;
        tick(3);
        btn = 1'b1;
        tick(8);
        check("glitch_btn", o_btn, 1'b1);
        check("glitch_hold", o_hold, 1'b1);
        check("glitch_no_release", n_rel - r0, 0);
        btn = 1'b0;
        tick(6);
        check("rel_early", o_release, 1'b0);
        tick(1);
        check("rel_strobe", o_release, 1'b1);
        check("rel_btn", o_btn, 1'b0);
        check("rel_hold", o_hold, 1'b0);
        tick(3);
        check("rel_count", n_rel - r0, 1);

        // Press bounce 1,0,1,1,0 then high
        tick(5);
        p0 = n_press;
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1; tick(1);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(1);
        btn = 1'b1;
        tick(6);
        check("bounce_no_press", n_press - p0, 0);
        check("bounce_btn_early", o_btn, 1'b0);
        tick(1);
        check("bounce_press", o_press, 1'b1);
        tick(2);
        check("bounce_press_count", n_press - p0, 1);

        // Reset mid-PRESSED with button held
        tick(4);
        rst = 1'b1;
        tick(1);
        check_zero_outputs("rst_pressed");
        rst = 1'b0;
        p0 = n_press;
        tick(6);
        check("rst_pressed_early", o_btn, 1'b0);
        tick(1);
        check("rst_pressed_press", o_press, 1'b1);
        tick(2);
        check("rst_pressed_count", n_press - p0, 1);

        // Reset mid-PRESS_WAIT with button held
        btn = 1'b0;
        tick(12);
        btn = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check_zero_outputs("rst_wait");
        rst = 1'b0;
        p0 = n_press;
        tick(6);
        check("rst_wait_early", o_press, 1'b0);
        tick(1);
        check("rst_wait_press", o_press, 1'b1);
        tick(2);
        check("rst_wait_count", n_press - p0, 1);
        btn = 1'b0;
        tick(12);

        // Randomised bounce-wrapped presses
        p0 = n_press;
        r0 = n_rel;
        for (int k = 0; k < 50; k++) begin
            bounce(1'b1);
            tick(int'($urandom_range(8, 30)));
            bounce(1'b0);
            tick(int'($urandom_range(8, 14)));
        end
        tick(4);
        check("rand_press_count", n_press - p0, 50);
        check("rand_release_count", n_rel - r0, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
